// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect -> exception vector).
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    PEND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_J    = 2'd2,
    SRC_JR   = 2'd3
  } redir_src_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;
  localparam logic [31:0] PC_INC               = 32'd4;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  // Redirect priority: jr beats jump beats a taken branch.
  function automatic redir_src_t pick_source(input logic jr, input logic jump,
                                             input logic br_taken);
    if (jr)            return SRC_JR;
    else if (jump)     return SRC_J;
    else if (br_taken) return SRC_BR;
    else               return SRC_NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// Combinational redirect target selection for pc_sequencer.
// With PC_ALIGN_CHECK_EN defined, a misaligned target is replaced by EXC_VECTOR
// and flagged on misaligned; otherwise targets pass through verbatim.
import pc_sequencer_pkg::*;

module pc_target_calc #(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [31:0] pc_plus4,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        redirect_valid,
  output logic        misaligned
);

  redir_src_t  src;
  logic [31:0] raw;

  // Pick the winning request, form its target, then apply the alignment substitution.
  always_comb begin
    src = pick_source(jr, jump, br_taken);
    raw = pc_plus4;
    case (src)
      SRC_JR:  raw = jr_target;
      SRC_J:   raw = {pc_plus4[31:28], jump_idx, 2'b00};
      SRC_BR:  raw = pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
      default: raw = pc_plus4;
    endcase
    redirect_valid = (src != SRC_NONE);
    misaligned     = ALIGN_CHECK && redirect_valid && (raw[1:0] != 2'b00);
    target         = misaligned ? EXC_VECTOR : raw;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential fetch, redirects, stall hold with a
// one-entry pending redirect buffer, and a one-cycle flush after each redirect.
// Optional feature macro: PC_ALIGN_CHECK_EN (sticky addr_err on misaligned redirect).
//
// Handshake: there is no ready/valid pair; stall=1 means "do not advance this
// cycle", and any redirect seen during a stall is held (latest wins) until the
// first cycle with stall=0, where a same-cycle redirect still takes precedence.
import pc_sequencer_pkg::*;

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        flush,
  output logic        addr_err
);

  state_t      state;
  logic [31:0] pend_target;
  logic        pend_err;
  logic [31:0] target;
  logic        redirect_valid;
  logic        misaligned;

  assign pc_plus4 = pc + PC_INC;

  pc_target_calc #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_target_calc (
    .pc_plus4      (pc_plus4),
    .br_taken      (br_taken),
    .br_imm        (br_imm),
    .jump          (jump),
    .jump_idx      (jump_idx),
    .jr            (jr),
    .jr_target     (jr_target),
    .target        (target),
    .redirect_valid(redirect_valid),
    .misaligned    (misaligned)
  );

  // Sequencer FSM: owns pc, pending redirect, and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pend_target <= '0;
      pend_err    <= 1'b0;
      pc_valid    <= 1'b0;
      flush       <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        BOOT: begin
          pc_valid <= 1'b1;
          state    <= RUN;
        end
        RUN, HOLD: begin
          if (stall) begin
            if (redirect_valid) begin
              pend_target <= target;
              pend_err    <= misaligned;
              state       <= PEND;
            end else begin
              state <= HOLD;
            end
          end else begin
            if (redirect_valid) begin
              pc    <= target;
              flush <= 1'b1;
              if (misaligned) addr_err <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
            state <= RUN;
          end
        end
        PEND: begin
          if (stall) begin
            if (redirect_valid) begin
              pend_target <= target;
              pend_err    <= misaligned;
            end
          end else begin
            if (redirect_valid) begin
              pc <= target;
              if (misaligned) addr_err <= 1'b1;
            end else begin
              pc <= pend_target;
              if (pend_err) addr_err <= 1'b1;
            end
            flush       <= 1'b1;
            pend_target <= '0;
            pend_err    <= 1'b0;
            state       <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run, all compared against a transaction-level reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jump;
  logic [25:0] jump_idx;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        flush;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit TB_ALIGN = 1'b1;
`else
  localparam bit TB_ALIGN = 1'b0;
`endif

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_flush;
  logic        m_err;
  logic        m_boot;
  logic [31:0] pend_q[$];

  pc_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .br_taken (br_taken),
    .br_imm   (br_imm),
    .jump     (jump),
    .jump_idx (jump_idx),
    .jr       (jr),
    .jr_target(jr_target),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .pc_valid (pc_valid),
    .flush    (flush),
    .addr_err (addr_err)
  );

  // Clock and global timeout.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_target(input logic [31:0] cur_pc);
    logic [31:0]        p4;
    logic signed [31:0] off;
    p4  = cur_pc + 32'd4;
    off = 32'(signed'(br_imm));
    if (jr)        return jr_target;
    else if (jump) return (p4 & 32'hF000_0000) | (32'(jump_idx) * 32'd4);
    else           return p4 + 32'(off * 4);
  endfunction

  task automatic model_apply(input logic [31:0] t);
    if (TB_ALIGN && (t % 4 != 0)) begin
      m_pc  = 32'h80;
      m_err = 1'b1;
    end else begin
      m_pc = t;
    end
    m_flush = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic        has_red;
    logic [31:0] t;
    has_red = jr | jump | br_taken;
    t       = ref_target(m_pc);
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_err = 1'b0; m_boot = 1'b1;
      pend_q.delete();
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1; m_flush = 1'b0;
    end else if (stall) begin
      m_flush = 1'b0;
      if (has_red) begin
        pend_q.delete();
        pend_q.push_back(t);
      end
    end else begin
      if (has_red)                model_apply(t);
      else if (pend_q.size() > 0) model_apply(pend_q[0]);
      else begin
        m_pc    = m_pc + 32'd4;
        m_flush = 1'b0;
      end
      pend_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; br_taken = 1'b0; br_imm = '0; jump = 1'b0; jump_idx = '0;
    jr = 1'b0; jr_target = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({pc, pc_valid, flush, addr_err} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got pc=%h v=%b f=%b e=%b want pc=0 v=0 f=0 e=0",
               pc, pc_valid, flush, addr_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pc !== exp_pc[i] || pc_valid !== 1'b1 || flush !== 1'b0) begin
        failures++;
        $display("FAIL boot_seq[%0d] got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, pc, pc_valid, flush, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    tick();
    checks++;
    if (pc !== 32'h10 || flush !== 1'b0) begin
      failures++; $display("FAIL br_pre got pc=%h f=%b want 00000010 0", pc, flush);
    end
    br_taken = 1'b1; br_imm = 16'hFFFE;
    tick();
    clear_inputs();
    checks++;
    if (pc !== 32'hC || flush !== 1'b1) begin
      failures++; $display("FAIL br_taken got pc=%h f=%b want 0000000c 1", pc, flush);
    end
    tick();
    checks++;
    if (pc !== 32'h10 || flush !== 1'b0) begin
      failures++; $display("FAIL br_after got pc=%h f=%b want 00000010 0", pc, flush);
    end
  endtask

  task automatic test_priority();
    jr = 1'b1; jr_target = 32'h2000_0010;
    tick();
    clear_inputs();
    jump = 1'b1; jump_idx = 26'h40; br_taken = 1'b1; br_imm = 16'h7FFF;
    tick();
    checks++;
    if (pc !== 32'h2000_0100 || flush !== 1'b1) begin
      failures++; $display("FAIL jump_over_br got pc=%h f=%b want 20000100 1", pc, flush);
    end
    jr = 1'b1; jr_target = 32'h1234_5678;
    tick();
    clear_inputs();
    checks++;
    if (pc !== 32'h1234_5678 || flush !== 1'b1) begin
      failures++; $display("FAIL jr_over_all got pc=%h f=%b want 12345678 1", pc, flush);
    end
    tick();
    checks++;
    if (pc !== 32'h1234_567C || flush !== 1'b0 || pc_plus4 !== 32'h1234_5680) begin
      failures++;
      $display("FAIL prio_after got pc=%h f=%b p4=%h want 1234567c 0 12345680", pc, flush, pc_plus4);
    end
  endtask

  task automatic test_stall_pend();
    jr = 1'b1; jr_target = 32'h100;
    tick();
    clear_inputs();
    stall = 1'b1;
    tick();
    jr = 1'b1; jr_target = 32'h400;
    tick();
    jr = 1'b0; jump = 1'b1; jump_idx = 26'h8;
    tick();
    checks++;
    if (pc !== 32'h100 || flush !== 1'b0) begin
      failures++; $display("FAIL stall_hold got pc=%h f=%b want 00000100 0", pc, flush);
    end
    clear_inputs();
    tick();
    checks++;
    if (pc !== 32'h20 || flush !== 1'b1) begin
      failures++; $display("FAIL pend_release got pc=%h f=%b want 00000020 1", pc, flush);
    end
    tick();
    checks++;
    if (pc !== 32'h24 || flush !== 1'b0) begin
      failures++; $display("FAIL pend_after got pc=%h f=%b want 00000024 0", pc, flush);
    end
  endtask

  task automatic test_reset_in_pend();
    logic [31:0] exp_pc[3] = '{32'h0, 32'h4, 32'h8};
    stall = 1'b1; jr = 1'b1; jr_target = 32'h300;
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || flush !== 1'b0) begin
      failures++; $display("FAIL pend_reset got pc=%h v=%b f=%b want 0 0 0", pc, pc_valid, flush);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== exp_pc[i] || pc_valid !== 1'b1 || flush !== 1'b0) begin
        failures++;
        $display("FAIL pend_reset_seq[%0d] got pc=%h v=%b f=%b want %h 1 0",
                 i, pc, pc_valid, flush, exp_pc[i]);
      end
    end
  endtask

  task automatic test_align();
    logic [31:0] want_pc;
    logic        want_err;
    want_pc  = TB_ALIGN ? 32'h80 : 32'h102;
    want_err = TB_ALIGN;
    jr = 1'b1; jr_target = 32'h102;
    tick();
    clear_inputs();
    checks++;
    if (pc !== want_pc || addr_err !== want_err || flush !== 1'b1) begin
      failures++;
      $display("FAIL align_jr got pc=%h e=%b f=%b want %h %b 1", pc, addr_err, flush, want_pc, want_err);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (pc !== want_pc + 32'd12 || addr_err !== want_err) begin
      failures++;
      $display("FAIL align_sticky got pc=%h e=%b want %h %b", pc, addr_err, want_pc + 32'd12, want_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (addr_err !== 1'b0) begin
      failures++; $display("FAIL align_clear got e=%b want 0", addr_err);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      stall     = ($urandom_range(0, 9) < 4);
      br_taken  = ($urandom_range(0, 3) == 0);
      br_imm    = 16'($urandom);
      jump      = ($urandom_range(0, 4) == 0);
      jump_idx  = 26'($urandom);
      jr        = ($urandom_range(0, 5) == 0);
      jr_target = ($urandom & 32'hFFFF_FFFC) |
                  (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      tick();
      checks++;
      if ({pc, pc_valid, flush, addr_err} !== {m_pc, m_valid, m_flush, m_err} ||
          pc_plus4 !== m_pc + 32'd4) begin
        failures++;
        $display("FAIL rand[%0d] got pc=%h p4=%h v=%b f=%b e=%b want pc=%h p4=%h v=%b f=%b e=%b",
                 n, pc, pc_plus4, pc_valid, flush, addr_err,
                 m_pc, m_pc + 32'd4, m_valid, m_flush, m_err);
      end
    end
    clear_inputs();
    rst = 1'b0;
  endtask

  // Test sequence and final report.
  initial begin
    rst = 1'b1;
    clear_inputs();
    m_pc = '0; m_valid = 1'b0; m_flush = 1'b0; m_err = 1'b0; m_boot = 1'b1;
    test_reset();
    test_branch();
    test_priority();
    test_stall_pend();
    test_reset_in_pend();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
